// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression engine: RPC rounds per clock, block chaining and an
// internally padded 256-bit nonce mode, with a valid/ready block input and a held digest output.
module sha256_iter_core #(
   parameter int unsigned RPC  = 1,
   parameter logic [31:0] IV_0 = 32'h6a09e667,
   parameter logic [31:0] IV_1 = 32'hbb67ae85,
   parameter logic [31:0] IV_2 = 32'h3c6ef372,
   parameter logic [31:0] IV_3 = 32'ha54ff53a,
   parameter logic [31:0] IV_4 = 32'h510e527f,
   parameter logic [31:0] IV_5 = 32'h9b05688c,
   parameter logic [31:0] IV_6 = 32'h1f83d9ab,
   parameter logic [31:0] IV_7 = 32'h5be0cd19
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_blk_valid,
   output logic         o_blk_ready,
   input  logic [511:0] i_blk_data,
   input  logic         i_blk_first,
   input  logic         i_blk_last,
   input  logic         i_blk_nonce,
   output logic         o_dig_valid,
   input  logic         i_dig_ready,
   output logic [255:0] o_dig_data,
   output logic         o_busy
);

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
      $error("sha256_iter_core: RPC must be 1, 2, 4 or 8");
   end

   localparam logic [255:0] IV        = {IV_0, IV_1, IV_2, IV_3, IV_4, IV_5, IV_6, IV_7};
   localparam logic [5:0]   RCNT_LAST = 6'(64 - RPC);
   localparam logic [5:0]   RCNT_STEP = 6'(RPC);

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_HOLD} state_t;

   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] sml_s0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sml_s1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   state_t               r_state;
   logic [5:0]           r_rcnt;
   logic [7:0][31:0]     r_v;       // index 7 = a ... index 0 = h
   logic [15:0][31:0]    r_w;       // index 15 = W[t] ... index 0 = W[t+15]
   logic [7:0][31:0]     r_base;
   logic [7:0][31:0]     r_chain;
   logic                 r_last;
   logic                 r_blk_ready;
   logic                 r_dig_valid;
   logic [255:0]         r_dig_data;
   logic                 r_busy;

   logic [7:0][31:0]     w_v;
   logic [15:0][31:0]    w_w;
   logic [31:0]          w_t1;
   logic [31:0]          w_t2;
   logic [31:0]          w_wn;
   logic [7:0][31:0]     w_sum;
   logic [511:0]         w_blk;
   logic [255:0]         w_base;

   assign o_blk_ready = r_blk_ready;
   assign o_dig_valid = r_dig_valid;
   assign o_dig_data  = r_dig_data;
   assign o_busy      = r_busy;

   // Block and base selection at accept; nonce mode always restarts from IV
   always_comb begin
      w_blk  = i_blk_nonce ? {i_blk_data[511:256], 32'h80000000, 192'h0, 32'h00000100} : i_blk_data;
      w_base = (i_blk_first || i_blk_nonce) ? IV : r_chain;
   end

   // RPC unrolled rounds with the schedule window sliding one word per round
   always_comb begin
      w_v  = r_v;
      w_w  = r_w;
      w_t1 = '0;
      w_t2 = '0;
      w_wn = '0;
      for (int unsigned i = 0; i < RPC; i++) begin
         w_t1 = w_v[0] + big_s1(w_v[3]) + ((w_v[3] & w_v[2]) ^ (~w_v[3] & w_v[1]))
              + K_TAB[r_rcnt + 6'(i)] + w_w[15];
         w_t2 = big_s0(w_v[7]) + ((w_v[7] & w_v[6]) ^ (w_v[7] & w_v[5]) ^ (w_v[6] & w_v[5]));
         w_wn = sml_s1(w_w[1]) + w_w[6] + sml_s0(w_w[14]) + w_w[15];
         w_v  = {w_t1 + w_t2, w_v[7:5], w_v[4] + w_t1, w_v[3:1]};
         w_w  = {w_w[14:0], w_wn};
      end
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < 8; i++) begin
         w_sum[i] = r_base[i] + r_v[i];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_rcnt      <= '0;
         r_v         <= '0;
         r_w         <= '0;
         r_base      <= IV;
         r_chain     <= IV;
         r_last      <= 1'b0;
         r_blk_ready <= 1'b1;
         r_dig_valid <= 1'b0;
         r_dig_data  <= '0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_blk_valid) begin
                  r_state     <= S_ROUND;
                  r_rcnt      <= '0;
                  r_w         <= w_blk;
                  r_v         <= w_base;
                  r_base      <= w_base;
                  r_last      <= i_blk_last | i_blk_nonce;
                  r_blk_ready <= 1'b0;
                  r_busy      <= 1'b1;
               end
            end
            S_ROUND: begin
               r_v <= w_v;
               r_w <= w_w;
               if (r_rcnt == RCNT_LAST) begin
                  r_state <= S_FINAL;
                  r_rcnt  <= '0;
               end else begin
                  r_rcnt <= r_rcnt + RCNT_STEP;
               end
            end
            S_FINAL: begin
               r_chain <= w_sum;
               if (r_last) begin
                  r_state     <= S_HOLD;
                  r_dig_data  <= w_sum;
                  r_dig_valid <= 1'b1;
               end else begin
                  r_state     <= S_IDLE;
                  r_blk_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            S_HOLD: begin
               if (i_dig_ready) begin
                  r_state     <= S_IDLE;
                  r_dig_valid <= 1'b0;
                  r_blk_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
